// File: rtl/mem_responder_pkg.sv
// Shared types for the external-memory responder: address/word types and FSM states.
package mem_responder_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int CNT_W     = 4;

    typedef logic [0:7]  mem_addr_t;
    typedef logic [0:63] word_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESP
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage with a priority preload write port, a core write port and one registered read port.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              ld_en,
    input  logic [0:ADDR_W-1] ld_addr,
    input  logic [0:DATA_W-1] ld_data,
    input  logic              wr_en,
    input  logic [0:ADDR_W-1] wr_addr,
    input  logic [0:DATA_W-1] wr_data,
    input  logic              rd_en,
    input  logic [0:ADDR_W-1] rd_addr,
    output logic [0:DATA_W-1] rd_data
);

    logic [0:DATA_W-1] mem [0:(2**ADDR_W)-1];

    // Contents are never reset. The preload write is issued last so it wins a same-address
    // collision, and the read samples the pre-edge contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (ld_en) mem[ld_addr] <= ld_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with fixed access latency.
//   state    | meaning
//   MEM_IDLE | ready for a request
//   MEM_WAIT | counting down the access latency; access happens when the counter reaches 0
//   MEM_RESP | response held until rsp_ready
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [0:ADDR_W-1] req_addr,
    input  logic [0:DATA_W-1] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [0:DATA_W-1] rsp_rdata,
    input  logic              ld_en,
    input  logic [0:ADDR_W-1] ld_addr,
    input  logic [0:DATA_W-1] ld_data
);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              latch;
    logic              access;
    logic              write_q;
    logic [0:ADDR_W-1] addr_q;
    logic [0:DATA_W-1] wdata_q;
    logic [0:DATA_W-1] rd_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        access  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (req_valid) begin
                    latch   = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = MEM_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MEM_RESP: begin
                if (rsp_ready) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // A reset forces MEM_IDLE asynchronously, so a pending store can never reach the array.
    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk     (clk),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .wr_en   (access & write_q),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_en   (access & ~write_q),
        .rd_addr (addr_q),
        .rd_data (rd_data)
    );

    assign req_ready = (state_q == MEM_IDLE);
    assign rsp_valid = (state_q == MEM_RESP);
    assign rsp_write = rsp_valid & write_q;
    // The read register is unreset and untouched outside an access; mask it outside load responses.
    assign rsp_rdata = (rsp_valid && !write_q) ? rd_data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: dut_a runs with LATENCY=2, dut_b with LATENCY=1 for same-edge collisions.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic        a_req_valid = 0, a_req_write = 0, a_rsp_ready = 1, a_ld_en = 0;
    logic [0:7]  a_req_addr = '0, a_ld_addr = '0;
    logic [0:63] a_req_wdata = '0, a_ld_data = '0;
    logic        a_req_ready, a_rsp_valid, a_rsp_write;
    logic [0:63] a_rsp_rdata;

    logic        b_req_valid = 0, b_req_write = 0, b_rsp_ready = 1, b_ld_en = 0;
    logic [0:7]  b_req_addr = '0, b_ld_addr = '0;
    logic [0:63] b_req_wdata = '0, b_ld_data = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_write;
    logic [0:63] b_rsp_rdata;

    mem_responder #(.ADDR_W(8), .DATA_W(64), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_write(a_rsp_write),
        .rsp_rdata(a_rsp_rdata),
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(64), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_write(b_rsp_write),
        .rsp_rdata(b_rsp_rdata),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
    );

    typedef struct {
        logic        w;
        logic [63:0] d;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic a_prev   = 1'b0;
    logic b_prev   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, required none", name);
    endtask

    // Monitors: compare every presented response against the front of the queue.
    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (qa.size() == 0) fail_now("a_unexpected_rsp");
            else begin
                if (!a_prev) check("a_latency", 64'(cyc - qa[0].acc), 64'(2));
                check("a_rsp_write", 64'(a_rsp_write), 64'(qa[0].w));
                check("a_rsp_rdata", 64'(a_rsp_rdata), qa[0].d);
                check("a_req_ready_busy", 64'(a_req_ready), 64'(0));
                if (a_rsp_ready) void'(qa.pop_front());
            end
        end
        a_prev = a_rsp_valid;
    end

    always @(negedge clk) begin
        if (b_rsp_valid) begin
            if (qb.size() == 0) fail_now("b_unexpected_rsp");
            else begin
                if (!b_prev) check("b_latency", 64'(cyc - qb[0].acc), 64'(1));
                check("b_rsp_write", 64'(b_rsp_write), 64'(qb[0].w));
                check("b_rsp_rdata", 64'(b_rsp_rdata), qb[0].d);
                if (b_rsp_ready) void'(qb.pop_front());
            end
        end
        b_prev = b_rsp_valid;
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic issue(input bit sel, input bit w, input logic [7:0] addr,
                         input logic [63:0] wd, input logic [63:0] exp_d);
        exp_t e;
        int   t = 0;
        while (!(sel ? b_req_ready : a_req_ready)) begin
            @(posedge clk); #1;
            t++;
            if (t > 50) begin
                fail_now("issue_ready_timeout");
                return;
            end
        end
        if (sel) begin
            b_req_valid = 1; b_req_write = w; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = 1; a_req_write = w; a_req_addr = addr; a_req_wdata = wd;
        end
        @(posedge clk); #1;
        a_req_valid = 0;
        b_req_valid = 0;
        e.w   = w;
        e.d   = w ? 64'h0 : exp_d;
        e.acc = cyc;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    task automatic preload(input bit sel, input logic [7:0] addr, input logic [63:0] d);
        if (sel) begin b_ld_en = 1; b_ld_addr = addr; b_ld_data = d; end
        else     begin a_ld_en = 1; a_ld_addr = addr; a_ld_data = d; end
        @(posedge clk); #1;
        a_ld_en = 0;
        b_ld_en = 0;
    endtask

    task automatic wait_idle(input bit sel);
        int t = 0;
        while (!(sel ? (qb.size() == 0 && b_req_ready) : (qa.size() == 0 && a_req_ready))) begin
            @(posedge clk); #1;
            t++;
            if (t > 50) begin
                fail_now("wait_idle_timeout");
                return;
            end
        end
    endtask

    initial begin
        int t;
        #2 rst = 1'b0;
        #1;
        check("rst_req_ready", 64'(a_req_ready), 64'(1));
        check("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
        check("rst_rsp_write", 64'(a_rsp_write), 64'(0));
        check("rst_rsp_rdata", 64'(a_rsp_rdata), 64'h0);
        @(posedge clk); #1;
        // Preloads while reset is held must still land in the array.
        preload(0, 8'hff, 64'h0f);
        preload(0, 8'h05, 64'h11);
        preload(0, 8'h10, 64'h1234);
        preload(1, 8'h07, 64'h44);
        rst = 1'b1;
        @(posedge clk); #1;

        issue(0, 0, 8'hff, 64'h0, 64'h0f);  wait_idle(0);
        issue(0, 1, 8'hfd, 64'hff, 64'h0);  wait_idle(0);
        issue(0, 0, 8'hfd, 64'h0, 64'hff);  wait_idle(0);

        // Backpressure: response must stay put while rsp_ready is low.
        a_rsp_ready = 0;
        issue(0, 0, 8'hff, 64'h0, 64'h0f);
        t = 0;
        while (!a_rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
        repeat (3) begin @(posedge clk); #1; end
        check("bp_hold_valid", 64'(a_rsp_valid), 64'(1));
        check("bp_hold_ready", 64'(a_req_ready), 64'(0));
        a_rsp_ready = 1;
        @(posedge clk); #1;
        check("bp_release_ready", 64'(a_req_ready), 64'(1));
        check("bp_release_valid", 64'(a_rsp_valid), 64'(0));

        // Requests raised while busy must be ignored entirely.
        issue(0, 1, 8'h30, 64'h55, 64'h0);
        a_req_valid = 1; a_req_write = 1; a_req_addr = 8'h10; a_req_wdata = 64'hdead;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_req_valid = 0;
        wait_idle(0);
        repeat (5) begin @(posedge clk); #1; end
        issue(0, 0, 8'h10, 64'h0, 64'h1234); wait_idle(0);
        issue(0, 0, 8'h30, 64'h0, 64'h55);   wait_idle(0);

        // Reset while a store is waiting: store dropped, nothing responds.
        issue(0, 1, 8'h05, 64'hAA, 64'h0);
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(a_rsp_valid), 64'(0));
        check("midrst_req_ready", 64'(a_req_ready), 64'(1));
        check("midrst_rsp_rdata", 64'(a_rsp_rdata), 64'h0);
        qa.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        issue(0, 0, 8'h05, 64'h0, 64'h11);  wait_idle(0);

        // LATENCY=1: preload and store commit on the same edge, preload wins.
        issue(1, 1, 8'h07, 64'h33, 64'h0);
        preload(1, 8'h07, 64'h22);
        wait_idle(1);
        issue(1, 0, 8'h07, 64'h0, 64'h22);  wait_idle(1);

        // LATENCY=1: load sample and preload on the same edge, load sees the old word.
        preload(1, 8'h07, 64'h44);
        issue(1, 0, 8'h07, 64'h0, 64'h44);
        preload(1, 8'h07, 64'h55);
        wait_idle(1);
        issue(1, 0, 8'h07, 64'h0, 64'h55);  wait_idle(1);

        repeat (3) begin @(posedge clk); #1; end
        check("a_queue_drained", 64'(qa.size()), 64'(0));
        check("b_queue_drained", 64'(qb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

endmodule
